// File: rtl/stonyman_sensor_model.sv
// Purpose: digital responder for the Stonyman control port; decodes the strobes into pointer/value/register bank and emits a test-pattern pixel.
// Latency: strobe effects visible after the rising edge; pixel follows register changes by one cycle.
// Backpressure: none; strobes are sampled every cycle and pixel_valid marks settled output.
module stonyman_sensor_model #(
    parameter int unsigned ARRAY_SIZE = 112,
    parameter int unsigned SETTLE     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       resp,
    input  logic       incp,
    input  logic       resv,
    input  logic       incv,
    input  logic       inphi,
    output logic [7:0] pixel,
    output logic       pixel_valid,
    output logic [2:0] pointer,
    output logic [7:0] value,
    output logic [7:0] reg_rowsel,
    output logic [7:0] reg_colsel,
    output logic [7:0] reg_config,
    output logic       write_strobe
);

    // Wide enough to hold SETTLE, and never zero bits wide when SETTLE is 0.
    localparam int CW = $clog2(SETTLE + 2);

    localparam logic [2:0] IDX_COLSEL = 3'd0;
    localparam logic [2:0] IDX_ROWSEL = 3'd1;
    localparam logic [2:0] IDX_CONFIG = 3'd5;

    logic [4:0]    strobes;
    logic [4:0]    prev;
    logic          first;
    logic [4:0]    ev;
    logic [7:0]    regs [0:7];
    logic [CW-1:0] settle_cnt;

    logic [2:0]    pointer_nxt;
    logic [7:0]    value_nxt;
    logic [CW-1:0] settle_nxt;
    logic [7:0]    config_nxt;
    logic          sat;

    assign strobes = {inphi, incv, resv, incp, resp};

    // While 'first' is set (the cycle right after reset release) every prev
    // flop looks high, so a strobe already asserted at release cannot fire.
    assign ev = strobes & ~(prev | {5{first}});

    assign reg_colsel = regs[IDX_COLSEL];
    assign reg_rowsel = regs[IDX_ROWSEL];
    assign reg_config = regs[IDX_CONFIG];

    // Next pointer/value/settle state; resets win over increments, and the
    // register write always sees the pre-update pointer and value.
    always_comb begin
        pointer_nxt = pointer;
        value_nxt   = value;
        settle_nxt  = settle_cnt;
        config_nxt  = regs[IDX_CONFIG];
        if (ev[0])      pointer_nxt = 3'd0;
        else if (ev[1]) pointer_nxt = pointer + 3'd1;
        if (ev[2])      value_nxt = 8'd0;
        else if (ev[3]) value_nxt = value + 8'd1;
        if (ev[4] && (pointer == IDX_COLSEL || pointer == IDX_ROWSEL))
            settle_nxt = CW'(SETTLE);
        else if (settle_cnt != '0)
            settle_nxt = settle_cnt - CW'(1);
        if (ev[4] && pointer == IDX_CONFIG)
            config_nxt = value;
    end

    // Address saturation on the currently stored row/column selects.
    always_comb begin
        sat = (32'(regs[IDX_ROWSEL]) >= ARRAY_SIZE) || (32'(regs[IDX_COLSEL]) >= ARRAY_SIZE);
    end

    // Edge-detect history and the post-release suppression flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev  <= 5'd0;
            first <= 1'b1;
        end else begin
            prev  <= strobes;
            first <= 1'b0;
        end
    end

    // Pointer, value, register bank, settling counter and write pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pointer      <= 3'd0;
            value        <= 8'd0;
            settle_cnt   <= '0;
            write_strobe <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= 8'd0;
        end else begin
            pointer      <= pointer_nxt;
            value        <= value_nxt;
            settle_cnt   <= settle_nxt;
            write_strobe <= ev[4];
            if (ev[4]) regs[pointer] <= value;
        end
    end

    // Test-pattern pixel from the stored registers; validity from the
    // updated config and settling state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel       <= 8'h00;
            pixel_valid <= 1'b0;
        end else begin
            if (regs[IDX_CONFIG] == 8'd0) pixel <= 8'h00;
            else if (sat)                 pixel <= 8'hFF;
            else                          pixel <= regs[IDX_ROWSEL] + regs[IDX_COLSEL];
            pixel_valid <= (config_nxt != 8'd0) && (settle_nxt == '0);
        end
    end

endmodule

// File: tb/tb_stonyman_sensor_model.sv
module tb_stonyman_sensor_model;

    localparam int SETTLE = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       resp = 1'b0, incp = 1'b0, resv = 1'b0, incv = 1'b0, inphi = 1'b0;
    logic [7:0] pixel, value, reg_rowsel, reg_colsel, reg_config;
    logic [2:0] pointer;
    logic       pixel_valid, write_strobe;

    stonyman_sensor_model #(.ARRAY_SIZE(112), .SETTLE(SETTLE)) dut (
        .clk(clk), .reset(reset),
        .resp(resp), .incp(incp), .resv(resv), .incv(incv), .inphi(inphi),
        .pixel(pixel), .pixel_valid(pixel_valid), .pointer(pointer), .value(value),
        .reg_rowsel(reg_rowsel), .reg_colsel(reg_colsel), .reg_config(reg_config),
        .write_strobe(write_strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int data;
        int ptr;
        int val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: sensor state as plain integers.
    int mptr = 0;
    int mval = 0;
    int mregs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_pixel();
        if (mregs[5] == 0) return 0;
        if (mregs[1] >= 112 || mregs[0] >= 112) return 255;
        return (mregs[1] + mregs[0]) % 256;
    endfunction

    task automatic model_reset();
        mptr = 0;
        mval = 0;
        for (int i = 0; i < 8; i++) mregs[i] = 0;
        exp_q.delete();
    endtask

    // m bits: 0 resp, 1 incp, 2 resv, 3 incv, 4 inphi
    task automatic model_step(input logic [4:0] m);
        int op, ov;
        op = mptr;
        ov = mval;
        if (m[4]) mregs[op] = ov;
        if (m[0])      mptr = 0;
        else if (m[1]) mptr = (mptr + 1) % 8;
        if (m[2])      mval = 0;
        else if (m[3]) mval = (mval + 1) % 256;
        if (m[4]) exp_q.push_back('{op, ov, mptr, mval});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [4:0] m);
        @(negedge clk);
        {inphi, incv, resv, incp, resp} = m;
        model_step(m);
        @(negedge clk);
        {inphi, incv, resv, incp, resp} = 5'b0;
    endtask

    task automatic set_ptr_val(input int idx, input int data);
        pulse(5'b00001);
        for (int i = 0; i < idx; i++) pulse(5'b00010);
        pulse(5'b00100);
        for (int i = 0; i < data; i++) pulse(5'b01000);
    endtask

    task automatic write_reg(input int idx, input int data);
        set_ptr_val(idx, data);
        pulse(5'b10000);
    endtask

    function automatic int reg_out(input int idx);
        case (idx)
            0: return int'(reg_colsel);
            1: return int'(reg_rowsel);
            default: return int'(reg_config);
        endcase
    endfunction

    // Scoreboard monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (reset && write_strobe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write_strobe: got 1 expected 0 at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_pointer", int'(pointer), e.ptr);
                chk("wr_value", int'(value), e.val);
                if (e.idx == 0 || e.idx == 1 || e.idx == 5)
                    chk($sformatf("wr_reg%0d", e.idx), reg_out(e.idx), e.data);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_pointer"}, int'(pointer), 0);
        chk({tag, "_value"}, int'(value), 0);
        chk({tag, "_pixel"}, int'(pixel), 0);
        chk({tag, "_pixel_valid"}, int'(pixel_valid), 0);
        chk({tag, "_write_strobe"}, int'(write_strobe), 0);
        chk({tag, "_rowsel"}, int'(reg_rowsel), 0);
        chk({tag, "_colsel"}, int'(reg_colsel), 0);
        chk({tag, "_config"}, int'(reg_config), 0);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_pointer"}, int'(pointer), mptr);
        chk({tag, "_value"}, int'(value), mval);
        chk({tag, "_rowsel"}, int'(reg_rowsel), mregs[1]);
        chk({tag, "_colsel"}, int'(reg_colsel), mregs[0]);
        chk({tag, "_config"}, int'(reg_config), mregs[5]);
    endtask

    task automatic check_steady_pixel(input string tag);
        idle(SETTLE + 3);
        chk({tag, "_pixel"}, int'(pixel), exp_pixel());
        chk({tag, "_pixel_valid"}, int'(pixel_valid), int'(mregs[5] != 0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        idle(3);
        check_all_zero("reset");
        reset = 1'b1;
        idle(2);

        // Program ROWSEL = 5 through pointer 1
        write_reg(1, 5);
        idle(2);
        chk("rowsel_pointer", int'(pointer), 1);
        chk("rowsel_value", int'(value), 5);
        chk("rowsel_reg", int'(reg_rowsel), 5);

        // Pointer and value wrap
        pulse(5'b00001);
        for (int i = 0; i < 8; i++) pulse(5'b00010);
        chk("ptr_wrap", int'(pointer), 0);
        pulse(5'b00100);
        for (int i = 0; i < 256; i++) pulse(5'b01000);
        chk("val_wrap", int'(value), 0);

        // incp held high fires once
        @(negedge clk);
        incp = 1'b1;
        model_step(5'b00010);
        idle(10);
        incp = 1'b0;
        idle(2);
        chk("incp_held", int'(pointer), 1);

        // resp + incp together: reset wins
        pulse(5'b00011);
        chk("resp_incp", int'(pointer), 0);

        // inphi + incv with value 9 into COLSEL
        set_ptr_val(0, 9);
        pulse(5'b11000);
        idle(2);
        chk("inphi_incv_reg", int'(reg_colsel), 9);
        chk("inphi_incv_val", int'(value), 10);

        // Settling: CONFIG=1, ROWSEL=3, then COLSEL=4 watched cycle by cycle
        write_reg(5, 1);
        write_reg(1, 3);
        set_ptr_val(0, 4);
        @(negedge clk);
        inphi = 1'b1;
        model_step(5'b10000);
        for (int k = 0; k < SETTLE; k++) begin
            @(negedge clk);
            inphi = 1'b0;
            chk($sformatf("settle_low%0d", k), int'(pixel_valid), 0);
        end
        @(negedge clk);
        chk("settle_high", int'(pixel_valid), 1);
        chk("settle_pixel", int'(pixel), 7);

        // Mid-operation reset with strobes held through release
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        incp = 1'b1;
        incv = 1'b1;
        idle(2);
        reset = 1'b1;
        idle(3);
        chk("held_release_ptr", int'(pointer), 0);
        chk("held_release_val", int'(value), 0);
        incp = 1'b0;
        incv = 1'b0;
        idle(2);
        pulse(5'b01010);
        chk("post_release_ptr", int'(pointer), 1);
        chk("post_release_val", int'(value), 1);

        // Saturated address and sleep
        write_reg(5, 1);
        write_reg(0, 4);
        write_reg(1, 112);
        check_steady_pixel("sat");
        write_reg(5, 0);
        check_steady_pixel("sleep");

        // Randomized strobe combinations
        for (int n = 0; n < 60; n++) pulse(5'($urandom_range(1, 31)));
        idle(2);
        check_state("rand");
        if (mregs[5] == 0) write_reg(5, 3);
        write_reg(1, $urandom_range(0, 120));
        write_reg(0, $urandom_range(0, 120));
        check_steady_pixel("rand");
        check_state("final");

        // Drain scoreboard
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
